// File: rtl/gate_arb_pkg.sv
// gate_arb_pkg: shared types and defaults for gate_access_arbiter and its round-robin picker.
package gate_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_GATE_LAT    = 1;
  localparam int DEF_RSP_TIMEOUT = 16;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gate_access_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first asserted request at or after i_ptr, wrapping.
module rr_pick
  import gate_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = idx_w(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_gid,
  output logic             o_any
);

  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest offset down so the closest hit to i_ptr is written last.
  always_comb begin
    o_grant = '0;
    o_gid   = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      w_idx = IDX_W'((int'(i_ptr) + off) % N_REQ);
      if (i_req[w_idx]) begin
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
        o_gid          = w_idx;
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_access_arbiter.sv
// gate_access_arbiter: round-robin sharing of one logic_gate among N_REQ requesters.
// Optional response timeout is enabled by defining GATE_ARB_RSP_TIMEOUT_EN.
//   state  | meaning
//   S_IDLE | pick a requester, accept its operand
//   S_WAIT | operand on gate, count down GATE_LAT, then capture result
//   S_RESP | present result to granted requester until accepted
module gate_access_arbiter
  import gate_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int GATE_LAT    = DEF_GATE_LAT,
  parameter int RSP_TIMEOUT = DEF_RSP_TIMEOUT
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [N_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]       o_rsp_data,
  input  logic [N_REQ-1:0]        i_rsp_ready,
  output logic [DATA_W-1:0]       o_gate_data,
  input  logic [DATA_W-1:0]       i_gate_data,
  output logic                    o_gate_rst_n,
  output logic                    o_busy,
  output logic                    o_timeout
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = $clog2(GATE_LAT + 2);

  if (N_REQ < 2 || N_REQ > 8 || GATE_LAT < 0 || RSP_TIMEOUT < 1) begin : g_param_err
    $error("gate_access_arbiter: illegal parameter set");
  end

  state_t            r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_gid;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_result;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic              r_busy;
  logic              r_gate_rst_n;

  logic [N_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]  w_gid;
  logic              w_any;
  logic [DATA_W-1:0] w_op;
  logic [N_REQ-1:0]  w_gid_oh;
  logic [IDX_W-1:0]  w_ptr_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_gid   (w_gid),
    .o_any   (w_any)
  );

  always_comb begin
    w_op = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant[k]) w_op = i_req_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_gid_oh        = '0;
    w_gid_oh[r_gid] = 1'b1;
  end

  assign w_ptr_next = (r_gid == IDX_W'(N_REQ - 1)) ? '0 : r_gid + 1'b1;

  // Ready is the only combinational output: the handshake must complete in the pick cycle.
  assign o_req_ready  = (r_state == S_IDLE && !i_rst) ? w_grant : '0;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_result;
  assign o_gate_data  = r_hold;
  assign o_gate_rst_n = r_gate_rst_n;
  assign o_busy       = r_busy;

`ifdef GATE_ARB_RSP_TIMEOUT_EN
  localparam int TO_W = $clog2(RSP_TIMEOUT + 1);
  logic [TO_W-1:0] r_tcnt;
  logic            r_timeout;
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_gid        <= '0;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_result     <= '0;
      r_rsp_valid  <= '0;
      r_busy       <= 1'b0;
      r_gate_rst_n <= 1'b0;
`ifdef GATE_ARB_RSP_TIMEOUT_EN
      r_tcnt       <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_gate_rst_n <= 1'b1;
`ifdef GATE_ARB_RSP_TIMEOUT_EN
      r_timeout    <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_hold  <= w_op;
            r_gid   <= w_gid;
            r_cnt   <= CNT_W'(GATE_LAT);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_result    <= i_gate_data;
            r_rsp_valid <= w_gid_oh;
            r_state     <= S_RESP;
`ifdef GATE_ARB_RSP_TIMEOUT_EN
            r_tcnt      <= TO_W'(RSP_TIMEOUT - 1);
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          // An accept on the expiry cycle wins over the timeout.
          if (i_rsp_ready[r_gid]) begin
            r_ptr       <= w_ptr_next;
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
`ifdef GATE_ARB_RSP_TIMEOUT_EN
          else if (r_tcnt == '0) begin
            r_ptr       <= w_ptr_next;
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt - 1'b1;
          end
`endif
        end
        default: begin
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_access_arbiter.sv
// tb_gate_access_arbiter: scenario tasks plus randomized traffic against a round-robin reference model.
// Define GATE_ARB_RSP_TIMEOUT_EN for both bench and RTL to exercise the response timeout.
module tb_gate_access_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 1;
  localparam int TO  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   rsp_ready = '0;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [W-1:0]   rsp_data, gate_o;
  logic [W-1:0]   gate_q = '0;
  logic           gate_rst_n, busy, timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int timeout_hits = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Gate model: one register stage computing ~x, reset by the arbiter's gate reset.
  always @(posedge clk) gate_q <= gate_rst_n ? ~gate_o : '0;
  always @(negedge clk) if (timeout === 1'b1) timeout_hits++;

  gate_access_arbiter #(
    .N_REQ (N), .DATA_W (W), .GATE_LAT (LAT), .RSP_TIMEOUT (TO)
  ) dut (
    .i_clk (clk), .i_rst (rst),
    .i_req_valid (req_valid), .i_req_data (req_data), .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid), .o_rsp_data (rsp_data), .i_rsp_ready (rsp_ready),
    .o_gate_data (gate_o), .i_gate_data (gate_q),
    .o_gate_rst_n (gate_rst_n), .o_busy (busy), .o_timeout (timeout)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input logic [W-1:0] d);
    req_data[k*W +: W] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Returns lat = number of cycles (counting the current one as 1) until rsp_valid, or -1.
  task automatic wait_rsp(output int lat);
    lat = 1;
    for (int i = 0; i < 12; i++) begin
      smp();
      if (rsp_valid !== '0) return;
      tick();
      lat++;
    end
    lat = -1;
  endtask

  task automatic drain();
    bit ok = 0;
    req_valid = '0; rsp_ready = '1;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (!busy && rsp_valid == '0) begin ok = 1; break; end
      tick();
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL drain: busy=%b rsp_valid=%b required idle", busy, rsp_valid); end
    tick();
    rsp_ready = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; rsp_ready = '1; req_data = {$urandom};
    for (int c = 0; c < 3; c++) begin
      tick(); smp();
      checks += 7;
      if (req_ready !== '0)  begin failures++; $display("FAIL rst_ready: got %b want 0", req_ready); end
      if (rsp_valid !== '0)  begin failures++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      if (rsp_data !== '0)   begin failures++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
      if (gate_o !== '0)     begin failures++; $display("FAIL rst_gate_data: got %h want 0", gate_o); end
      if (gate_rst_n !== 0)  begin failures++; $display("FAIL rst_gate_rst_n: got %b want 0", gate_rst_n); end
      if (busy !== 0)        begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (timeout !== 0)     begin failures++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    end
    tick(); rst = 1'b0; req_valid = '0; rsp_ready = '0;
    smp();
    checks++;
    if (gate_rst_n !== 0) begin failures++; $display("FAIL gate_rst_n_early: got %b want 0", gate_rst_n); end
    tick(); smp();
    checks++;
    if (gate_rst_n !== 1) begin failures++; $display("FAIL gate_rst_n_rise: got %b want 1", gate_rst_n); end
    tick();
  endtask

  task automatic test_single();
    logic [W-1:0] op = 8'h3C;
    do_reset();
    set_req(2, op); req_valid = 4'b0100;
    smp();
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick(); req_valid = '0;
    smp();
    checks += 3;
    if (busy !== 1)     begin failures++; $display("FAIL single_busy: got %b want 1", busy); end
    if (gate_o !== op)  begin failures++; $display("FAIL single_gate_data: got %h want %h", gate_o, op); end
    if (rsp_valid !== '0) begin failures++; $display("FAIL single_early_rsp_t1: got %b want 0", rsp_valid); end
    tick(); smp();
    checks++;
    if (rsp_valid !== '0) begin failures++; $display("FAIL single_early_rsp_t2: got %b want 0", rsp_valid); end
    tick(); smp();
    checks += 2;
    if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL single_rsp_valid: got %b want 0100", rsp_valid); end
    if (rsp_data !== ~op)      begin failures++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, ~op); end
    rsp_ready = 4'b0100;
    tick(); rsp_ready = '0;
    smp();
    checks += 3;
    if (busy !== 0)        begin failures++; $display("FAIL single_idle: busy=%b want 0", busy); end
    if (rsp_valid !== '0)  begin failures++; $display("FAIL single_rsp_drop: got %b want 0", rsp_valid); end
    if (rsp_data !== ~op)  begin failures++; $display("FAIL single_rsp_hold: got %h want %h", rsp_data, ~op); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [W-1:0] d [N];
    int g_idx [5];
    int g_cyc [5];
    int g_cnt = 0;
    int last_g = -1;
    do_reset();
    for (int k = 0; k < N; k++) begin d[k] = W'($urandom); set_req(k, d[k]); end
    req_valid = '1; rsp_ready = '1;
    for (int c = 0; c < 30 && g_cnt < 5; c++) begin
      smp();
      if (rsp_valid !== '0 && last_g >= 0) begin
        checks += 2;
        if (rsp_valid !== (N'(1) << last_g)) begin failures++; $display("FAIL rr_rsp_valid: got %b want %b", rsp_valid, N'(1) << last_g); end
        if (rsp_data !== ~d[last_g]) begin failures++; $display("FAIL rr_rsp_data: got %h want %h", rsp_data, ~d[last_g]); end
      end
      if (req_ready !== '0) begin
        g_idx[g_cnt] = -1;
        if ($countones(req_ready) == 1)
          for (int k = 0; k < N; k++) if (req_ready[k]) g_idx[g_cnt] = k;
        g_cyc[g_cnt] = cyc;
        last_g = g_idx[g_cnt];
        g_cnt++;
      end
      tick();
    end
    checks++;
    if (g_cnt != 5) begin failures++; $display("FAIL rr_grant_count: got %0d want 5", g_cnt); end
    for (int i = 0; i < g_cnt; i++) begin
      checks++;
      if (g_idx[i] != i % N) begin failures++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, g_idx[i], i % N); end
      if (i > 0) begin
        checks++;
        if (g_cyc[i] - g_cyc[i-1] != LAT + 3) begin
          failures++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", i, g_cyc[i] - g_cyc[i-1], LAT + 3);
        end
      end
    end
    drain();
  endtask

  task automatic test_stall();
    int lat;
    do_reset();
    set_req(1, 8'hF0); set_req(0, 8'h55);
    req_valid = 4'b0010; rsp_ready = 4'b1101;
    smp();
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL stall_grant1: got %b want 0010", req_ready); end
    tick(); req_valid = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      smp();
      checks++;
      if (req_ready !== '0) begin failures++; $display("FAIL stall_ready_busy[%0d]: got %b want 0", c, req_ready); end
      if (c >= 2) begin
        checks += 2;
        if (rsp_valid !== 4'b0010) begin failures++; $display("FAIL stall_rsp_valid[%0d]: got %b want 0010", c, rsp_valid); end
        if (rsp_data !== 8'h0F)    begin failures++; $display("FAIL stall_rsp_data[%0d]: got %h want 0f", c, rsp_data); end
      end
      if (c == 7) rsp_ready = 4'b0010;
      tick();
    end
    rsp_ready = '0;
    smp();
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL stall_next_grant: got %b want 0001", req_ready); end
    tick(); req_valid = '0;
    wait_rsp(lat);
    checks += 2;
    if (lat != LAT + 2) begin failures++; $display("FAIL stall_req0_latency: got %0d want %0d", lat, LAT + 2); end
    if (rsp_data !== 8'hAA) begin failures++; $display("FAIL stall_req0_data: got %h want aa", rsp_data); end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(1, 8'h11); set_req(3, 8'h33);
    req_valid = 4'b0010;
    smp();
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL rmid_pre_grant: got %b want 0010", req_ready); end
    tick(); req_valid = '0;
    drain();
    set_req(2, 8'h22); req_valid = 4'b0100;
    smp();
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL rmid_grant2: got %b want 0100", req_ready); end
    tick(); req_valid = '0; rst = 1'b1;
    smp();
    checks++;
    if (busy !== 1) begin failures++; $display("FAIL rmid_in_wait: busy=%b want 1", busy); end
    tick(); req_valid = 4'b1010;
    smp();
    checks += 6;
    if (rsp_valid !== '0) begin failures++; $display("FAIL rmid_rsp_valid: got %b want 0", rsp_valid); end
    if (busy !== 0)       begin failures++; $display("FAIL rmid_busy: got %b want 0", busy); end
    if (gate_o !== '0)    begin failures++; $display("FAIL rmid_gate_data: got %h want 0", gate_o); end
    if (rsp_data !== '0)  begin failures++; $display("FAIL rmid_rsp_data: got %h want 0", rsp_data); end
    if (gate_rst_n !== 0) begin failures++; $display("FAIL rmid_gate_rst_n: got %b want 0", gate_rst_n); end
    if (req_ready !== '0) begin failures++; $display("FAIL rmid_ready_forced: got %b want 0", req_ready); end
    tick(); rst = 1'b0;
    smp();
    checks += 2;
    if (rsp_valid !== '0)      begin failures++; $display("FAIL rmid_no_rsp: got %b want 0", rsp_valid); end
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL rmid_post_grant: got %b want 0010", req_ready); end
    tick(); req_valid = '0;
    drain();
  endtask

  task automatic test_withdrawn();
    bit saw3 = 0, rsp3 = 0, got0 = 0;
    do_reset();
    set_req(0, 8'h5A); set_req(3, 8'hC7);
    req_valid = 4'b0001;
    smp();
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL wd_grant0: got %b want 0001", req_ready); end
    tick(); req_valid = 4'b1000;
    smp();
    if (req_ready[3]) saw3 = 1;
    tick(); req_valid = '0; rsp_ready = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      smp();
      if (req_ready[3]) saw3 = 1;
      if (rsp_valid[3]) rsp3 = 1;
      if (rsp_valid[0] && rsp_data === 8'hA5) got0 = 1;
      tick();
    end
    checks += 3;
    if (saw3) begin failures++; $display("FAIL wd_never_granted: saw ready[3]=1 want never"); end
    if (rsp3) begin failures++; $display("FAIL wd_no_response: saw rsp_valid[3]=1 want never"); end
    if (!got0) begin failures++; $display("FAIL wd_req0_response: got none want a5"); end
    drain();
  endtask

  task automatic test_random();
    int ptr_m, g, lat, stall;
    logic [N-1:0] v, oh;
    logic [W-1:0] op;
    do_reset();
    ptr_m = 0;
    for (int t = 0; t < 25; t++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) set_req(k, W'($urandom));
      req_valid = v; rsp_ready = '0;
      g = -1;
      for (int i = N - 1; i >= 0; i--) if (v[(ptr_m + i) % N]) g = (ptr_m + i) % N;
      oh = N'(1) << g;
      op = req_data[g*W +: W];
      smp();
      checks++;
      if (req_ready !== oh) begin failures++; $display("FAIL rand_grant[%0d]: got %b want %b", t, req_ready, oh); end
      tick(); req_valid = '0;
      wait_rsp(lat);
      checks += 4;
      if (lat != LAT + 2)   begin failures++; $display("FAIL rand_latency[%0d]: got %0d want %0d", t, lat, LAT + 2); end
      if (rsp_valid !== oh) begin failures++; $display("FAIL rand_rsp_valid[%0d]: got %b want %b", t, rsp_valid, oh); end
      if (rsp_data !== ~op) begin failures++; $display("FAIL rand_rsp_data[%0d]: got %h want %h", t, rsp_data, ~op); end
      if (gate_o !== op)    begin failures++; $display("FAIL rand_gate_data[%0d]: got %h want %h", t, gate_o, op); end
      stall = $urandom_range(0, 3);
      repeat (stall) begin
        rsp_ready = ~oh;
        tick(); smp();
        checks++;
        if (rsp_valid !== oh) begin failures++; $display("FAIL rand_stall_hold[%0d]: got %b want %b", t, rsp_valid, oh); end
      end
      rsp_ready = oh;
      tick(); rsp_ready = '0;
      ptr_m = (g + 1) % N;
    end
  endtask

`ifdef GATE_ARB_RSP_TIMEOUT_EN
  task automatic test_timeout();
    int lat, e_cyc, t_cyc;
    do_reset();
    set_req(0, 8'h81); set_req(1, 8'h42);
    req_valid = 4'b0001;
    smp();
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL to_grant0: got %b want 0001", req_ready); end
    tick(); req_valid = '0;
    wait_rsp(lat);
    e_cyc = cyc;
    t_cyc = -1;
    for (int c = 0; c < 40; c++) begin
      tick(); smp();
      if (timeout === 1'b1) begin t_cyc = cyc; break; end
    end
    checks += 3;
    if (t_cyc - e_cyc != TO) begin failures++; $display("FAIL to_pulse_time: got %0d want %0d", t_cyc - e_cyc, TO); end
    if (busy !== 0)       begin failures++; $display("FAIL to_idle: busy=%b want 0", busy); end
    if (rsp_valid !== '0) begin failures++; $display("FAIL to_rsp_dropped: got %b want 0", rsp_valid); end
    tick(); req_valid = 4'b0011;
    smp();
    checks += 2;
    if (timeout !== 0)         begin failures++; $display("FAIL to_one_cycle: got %b want 0", timeout); end
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL to_ptr_advanced: got %b want 0010", req_ready); end
    tick(); req_valid = '0;
    drain();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_withdrawn();
    test_random();
`ifdef GATE_ARB_RSP_TIMEOUT_EN
    test_timeout();
    checks++;
    if (timeout_hits != 1) begin failures++; $display("FAIL timeout_count: got %0d want 1", timeout_hits); end
`else
    checks++;
    if (timeout_hits != 0) begin failures++; $display("FAIL timeout_count: got %0d want 0", timeout_hits); end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
